mem_bus_arbiter: RTL and testbench

- Shares the single external memory bus between the fetch stage (instruction reads) and the memory stage (data loads/stores, atomic lock).
- Fixed data-over-fetch priority, with a starvation guard for fetch.
- Honours bus_lock to keep read-modify-write sequences atomic.
- Enforces a bus-ack timeout so a dead slave cannot hang the pipeline.

---
 rtl/mem_bus_arbiter.sv | 203 ++++++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// Two-port external memory bus arbiter: data port over fetch port,
// with fetch starvation guard, data-port bus lock and ack timeout.
module mem_bus_arbiter #(
    parameter int unsigned STARVE_LIMIT   = 4,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        async_rst_n,
    input  logic        if_req,
    input  logic [29:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_valid,
    output logic        if_err,
    input  logic        d_req,
    input  logic [29:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_mask,
    input  logic        d_we,
    input  logic        d_lock,
    output logic [31:0] d_rdata,
    output logic        d_valid,
    output logic        d_err,
    output logic        bus_req,
    output logic [29:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_mask,
    output logic        bus_we,
    output logic        bus_lock,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    localparam int unsigned AW = 30;
    localparam int unsigned DW = 32;
    localparam int unsigned MW = 4;
    localparam int unsigned SW = 4;
    localparam int unsigned TW = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IF_BUSY = 2'd1,
        D_BUSY  = 2'd2,
        D_HOLD  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [SW-1:0] starve_q, starve_d;
    logic [TW-1:0] tout_q, tout_d;
    logic          glock_q, glock_d;

    logic          bus_req_d, bus_we_d, bus_lock_d;
    logic [AW-1:0] bus_addr_d;
    logic [DW-1:0] bus_wdata_d;
    logic [MW-1:0] bus_mask_d;
    logic [DW-1:0] if_rdata_d, d_rdata_d;
    logic          if_valid_d, if_err_d, d_valid_d, d_err_d;
    logic          grant_d, grant_f;

    // Next-state, arbitration, completion/timeout and all registered outputs
    always_comb begin
        state_d     = state_q;
        starve_d    = starve_q;
        tout_d      = tout_q;
        glock_d     = glock_q;
        bus_req_d   = bus_req;
        bus_addr_d  = bus_addr;
        bus_wdata_d = bus_wdata;
        bus_mask_d  = bus_mask;
        bus_we_d    = bus_we;
        bus_lock_d  = bus_lock;
        if_rdata_d  = if_rdata;
        d_rdata_d   = d_rdata;
        if_valid_d  = 1'b0;
        if_err_d    = 1'b0;
        d_valid_d   = 1'b0;
        d_err_d     = 1'b0;
        grant_d     = 1'b0;
        grant_f     = 1'b0;

        case (state_q)
            IDLE: begin
                if (d_req && ((starve_q < SW'(STARVE_LIMIT)) || !if_req)) begin
                    grant_d = 1'b1;
                end else if (if_req) begin
                    grant_f = 1'b1;
                end
            end
            D_HOLD: begin
                // Locked: only the data port may use the bus
                if (d_req) begin
                    grant_d = 1'b1;
                end else if (!d_lock) begin
                    bus_lock_d = 1'b0;
                    state_d    = IDLE;
                end
            end
            IF_BUSY, D_BUSY: begin
                if (bus_ack) begin
                    bus_req_d = 1'b0;
                    if (state_q == IF_BUSY) begin
                        if_valid_d = 1'b1;
                        if_rdata_d = bus_rdata;
                        state_d    = IDLE;
                    end else begin
                        d_valid_d = 1'b1;
                        d_rdata_d = bus_rdata;
                        if (glock_q) begin
                            state_d = D_HOLD;
                        end else begin
                            bus_lock_d = 1'b0;
                            state_d    = IDLE;
                        end
                    end
                end else if (tout_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    // Slave never answered: abort with error, drop any lock
                    bus_req_d  = 1'b0;
                    bus_lock_d = 1'b0;
                    state_d    = IDLE;
                    if (state_q == IF_BUSY) begin
                        if_valid_d = 1'b1;
                        if_err_d   = 1'b1;
                        if_rdata_d = '0;
                    end else begin
                        d_valid_d = 1'b1;
                        d_err_d   = 1'b1;
                        d_rdata_d = '0;
                    end
                end else begin
                    tout_d = tout_q + TW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (grant_d) begin
            bus_req_d   = 1'b1;
            bus_addr_d  = d_addr;
            bus_wdata_d = d_wdata;
            bus_mask_d  = d_mask;
            bus_we_d    = d_we;
            bus_lock_d  = bus_lock | d_lock;
            glock_d     = d_lock;
            tout_d      = '0;
            state_d     = D_BUSY;
        end else if (grant_f) begin
            bus_req_d   = 1'b1;
            bus_addr_d  = if_addr;
            bus_wdata_d = '0;
            bus_mask_d  = {MW{1'b1}};
            bus_we_d    = 1'b0;
            glock_d     = 1'b0;
            tout_d      = '0;
            state_d     = IF_BUSY;
        end

        // Consecutive data grants seen by a waiting fetch
        if (!if_req || grant_f) begin
            starve_d = '0;
        end else if (grant_d && (starve_q < SW'(STARVE_LIMIT))) begin
            starve_d = starve_q + SW'(1);
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            state_q   <= IDLE;
            starve_q  <= '0;
            tout_q    <= '0;
            glock_q   <= 1'b0;
            bus_req   <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            bus_mask  <= '0;
            bus_we    <= 1'b0;
            bus_lock  <= 1'b0;
            if_rdata  <= '0;
            if_valid  <= 1'b0;
            if_err    <= 1'b0;
            d_rdata   <= '0;
            d_valid   <= 1'b0;
            d_err     <= 1'b0;
        end else begin
            state_q   <= state_d;
            starve_q  <= starve_d;
            tout_q    <= tout_d;
            glock_q   <= glock_d;
            bus_req   <= bus_req_d;
            bus_addr  <= bus_addr_d;
            bus_wdata <= bus_wdata_d;
            bus_mask  <= bus_mask_d;
            bus_we    <= bus_we_d;
            bus_lock  <= bus_lock_d;
            if_rdata  <= if_rdata_d;
            if_valid  <= if_valid_d;
            if_err    <= if_err_d;
            d_rdata   <= d_rdata_d;
            d_valid   <= d_valid_d;
            d_err     <= d_err_d;
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: expected grants and completions are
// queued by the stimulus and consumed by a monitor as the DUT presents them.
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        async_rst_n;
    logic        if_req;
    logic [29:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_valid, if_err;
    logic        d_req;
    logic [29:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_mask;
    logic        d_we, d_lock;
    logic [31:0] d_rdata;
    logic        d_valid, d_err;
    logic        bus_req;
    logic [29:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_mask;
    logic        bus_we, bus_lock;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.STARVE_LIMIT(4), .TIMEOUT_CYCLES(64)) dut (
        .clk(clk), .async_rst_n(async_rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
        .if_valid(if_valid), .if_err(if_err),
        .d_req(d_req), .d_addr(d_addr), .d_wdata(d_wdata), .d_mask(d_mask),
        .d_we(d_we), .d_lock(d_lock), .d_rdata(d_rdata),
        .d_valid(d_valid), .d_err(d_err),
        .bus_req(bus_req), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_mask(bus_mask), .bus_we(bus_we), .bus_lock(bus_lock),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata)
    );

    typedef struct {
        logic        is_d;
        logic [29:0] addr;
        logic [3:0]  mask;
        logic        we;
        logic        lock;
        logic [31:0] wdata;
    } gnt_t;

    typedef struct {
        logic        is_d;
        logic        err;
        logic [31:0] rdata;
    } rsp_t;

    gnt_t gq[$];
    rsp_t rq[$];

    int   n_checks = 0;
    int   n_errors = 0;
    int   ack_at = 0;
    logic inject_ack = 1'b0;

    // Slave read data as a function of the word address
    function automatic logic [31:0] rd_of(input logic [29:0] a);
        if (a == 30'h10) return 32'hDEADBEEF;
        return {2'b10, a} ^ 32'h5A5A_0000;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic exp_gnt(input logic is_d, input logic [29:0] a, input logic [3:0] m,
                           input logic we, input logic lk, input logic [31:0] wd);
        gnt_t g;
        g.is_d = is_d; g.addr = a; g.mask = m; g.we = we; g.lock = lk; g.wdata = wd;
        gq.push_back(g);
    endtask

    task automatic exp_rsp(input logic is_d, input logic err, input logic [31:0] rd);
        rsp_t r;
        r.is_d = is_d; r.err = err; r.rdata = rd;
        rq.push_back(r);
    endtask

    task automatic check_rsp(input logic is_d);
        rsp_t        e;
        logic        err;
        logic [31:0] rd;
        err = is_d ? d_err : if_err;
        rd  = is_d ? d_rdata : if_rdata;
        if (rq.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_valid: port %0d err %0d rdata %0h, expected no completion",
                     is_d, err, rd);
        end else begin
            e = rq.pop_front();
            chk(is_d ? "d_response" : "if_response",
                128'({is_d, err, rd}), 128'({e.is_d, e.err, e.rdata}));
        end
    endtask

    // Slave: ack on the ack_at-th consecutive bus_req cycle (0 = never)
    initial begin : slave
        int run;
        run       = 0;
        bus_ack   = 1'b0;
        bus_rdata = '0;
        forever begin
            @(posedge clk);
            #2;
            if (bus_req) run++;
            else run = 0;
            bus_ack   = ((ack_at != 0) && (run == ack_at)) || inject_ack;
            bus_rdata = bus_ack ? rd_of(bus_addr) : 32'h0;
        end
    end

    // Monitor: compare each new bus transaction and each completion pulse
    initial begin : monitor
        logic        prev;
        gnt_t        g;
        logic [31:0] wd;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (async_rst_n) begin
                if (bus_req && !prev) begin
                    if (gq.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL unexpected_grant: addr %0h, expected no grant", bus_addr);
                    end else begin
                        g  = gq.pop_front();
                        wd = g.is_d ? bus_wdata : 32'h0;
                        chk(g.is_d ? "d_grant" : "if_grant",
                            128'({bus_addr, bus_mask, bus_we, bus_lock, wd}),
                            128'({g.addr, g.mask, g.we, g.lock, g.wdata}));
                    end
                end
                if (if_valid) check_rsp(1'b0);
                if (d_valid) check_rsp(1'b1);
            end
            prev = bus_req;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input logic is_d, input int budget, input string name,
                              output int cycles);
        cycles = -1;
        for (int c = 1; c <= budget; c++) begin
            tick();
            if (is_d ? d_valid : if_valid) begin
                cycles = c;
                return;
            end
        end
        n_checks++;
        n_errors++;
        $display("FAIL %s: no completion within %0d cycles", name, budget);
    endtask

    task automatic set_d(input logic [29:0] a, input logic we, input logic [3:0] m,
                         input logic [31:0] wd, input logic lk);
        d_addr = a; d_we = we; d_mask = m; d_wdata = wd; d_lock = lk;
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : stim
        int c, hi, got, vcount;
        async_rst_n = 1'b0;
        if_req = 1'b0; if_addr = '0;
        d_req = 1'b0;
        set_d(30'h0, 1'b0, 4'h0, 32'h0, 1'b0);

        // Reset
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", 128'({bus_req, bus_addr, bus_wdata, bus_mask, bus_we, bus_lock,
                                   if_valid, if_err, d_valid, d_err}), 128'(0));
        chk("reset_rdata", 128'({if_rdata, d_rdata}), 128'(0));
        @(negedge clk);
        async_rst_n = 1'b1;
        tick(); tick();
        chk("idle_outputs", 128'({bus_req, bus_lock, if_valid, d_valid}), 128'(0));

        // Single fetch, ack on second bus cycle
        ack_at = 2;
        exp_gnt(1'b0, 30'h10, 4'hF, 1'b0, 1'b0, 32'h0);
        exp_rsp(1'b0, 1'b0, 32'hDEADBEEF);
        if_req = 1'b1; if_addr = 30'h10;
        hi = 0; c = -1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (bus_req) hi++;
            if (if_valid) begin c = k; break; end
        end
        if_req = 1'b0;
        chk("fetch_latency", 128'(c), 128'(3));
        chk("fetch_busreq_cycles", 128'(hi), 128'(2));
        tick(); tick();
        chk("if_rdata_hold", 128'(if_rdata), 128'(32'hDEADBEEF));

        // Starvation guard: D,D,D,D,F,D,D,D,D,F
        ack_at = 1;
        for (int i = 0; i < 10; i++) begin
            if ((i % 5) == 4) begin
                exp_gnt(1'b0, 30'h200, 4'hF, 1'b0, 1'b0, 32'h0);
                exp_rsp(1'b0, 1'b0, rd_of(30'h200));
            end else begin
                exp_gnt(1'b1, 30'h100, 4'hF, 1'b0, 1'b0, 32'h0);
                exp_rsp(1'b1, 1'b0, rd_of(30'h100));
            end
        end
        set_d(30'h100, 1'b0, 4'hF, 32'h0, 1'b0);
        d_req = 1'b1; if_req = 1'b1; if_addr = 30'h200;
        got = 0;
        for (int k = 0; k < 200 && got < 10; k++) begin
            tick();
            got += int'(if_valid) + int'(d_valid);
        end
        d_req = 1'b0; if_req = 1'b0;
        chk("starve_completions", 128'(got), 128'(10));
        tick(); tick();

        // Locked read-modify-write with fetch waiting
        exp_gnt(1'b1, 30'h20, 4'hF, 1'b0, 1'b1, 32'h0);
        exp_rsp(1'b1, 1'b0, rd_of(30'h20));
        exp_gnt(1'b1, 30'h20, 4'h3, 1'b1, 1'b1, 32'h0000_BEEF);
        exp_rsp(1'b1, 1'b0, rd_of(30'h20));
        exp_gnt(1'b1, 30'h21, 4'hF, 1'b1, 1'b1, 32'h1234_5678);
        exp_rsp(1'b1, 1'b0, rd_of(30'h21));
        exp_gnt(1'b0, 30'h300, 4'hF, 1'b0, 1'b0, 32'h0);
        exp_rsp(1'b0, 1'b0, rd_of(30'h300));
        set_d(30'h20, 1'b0, 4'hF, 32'h0, 1'b1);
        d_req = 1'b1; if_req = 1'b1; if_addr = 30'h300;
        wait_valid(1'b1, 20, "lock_step1", c);
        chk("lock_held1", 128'(bus_lock), 128'(1));
        set_d(30'h20, 1'b1, 4'h3, 32'h0000_BEEF, 1'b1);
        wait_valid(1'b1, 20, "lock_step2", c);
        chk("lock_held2", 128'(bus_lock), 128'(1));
        set_d(30'h21, 1'b1, 4'hF, 32'h1234_5678, 1'b0);
        wait_valid(1'b1, 20, "lock_step3", c);
        chk("lock_released", 128'(bus_lock), 128'(0));
        d_req = 1'b0;
        wait_valid(1'b0, 20, "lock_fetch", c);
        if_req = 1'b0;
        tick();

        // Lock release from hold without a further grant
        exp_gnt(1'b1, 30'h30, 4'hF, 1'b0, 1'b1, 32'h0);
        exp_rsp(1'b1, 1'b0, rd_of(30'h30));
        set_d(30'h30, 1'b0, 4'hF, 32'h0, 1'b1);
        d_req = 1'b1;
        wait_valid(1'b1, 20, "hold_read", c);
        d_req = 1'b0;
        tick();
        chk("hold_lock_idle_bus", 128'({bus_lock, bus_req}), 128'(2'b10));
        d_lock = 1'b0;
        tick();
        chk("hold_release", 128'({bus_lock, bus_req}), 128'(0));
        tick();

        // Timeout on a locked write
        ack_at = 0;
        exp_gnt(1'b1, 30'h40, 4'hC, 1'b1, 1'b1, 32'hCAFE_F00D);
        exp_rsp(1'b1, 1'b1, 32'h0);
        set_d(30'h40, 1'b1, 4'hC, 32'hCAFE_F00D, 1'b1);
        d_req = 1'b1;
        hi = 0; c = -1;
        for (int k = 1; k <= 200; k++) begin
            tick();
            if (bus_req) hi++;
            if (d_valid) begin c = k; break; end
        end
        d_req = 1'b0; d_lock = 1'b0;
        chk("timeout_busreq_cycles", 128'(hi), 128'(64));
        chk("timeout_latency", 128'(c), 128'(65));
        chk("timeout_after", 128'({bus_lock, bus_req}), 128'(0));
        ack_at = 1;
        exp_gnt(1'b0, 30'h50, 4'hF, 1'b0, 1'b0, 32'h0);
        exp_rsp(1'b0, 1'b0, rd_of(30'h50));
        if_req = 1'b1; if_addr = 30'h50;
        wait_valid(1'b0, 20, "post_timeout_fetch", c);
        if_req = 1'b0;
        chk("d_rdata_hold", 128'(d_rdata), 128'(0));
        tick();

        // Ack on the expiry cycle completes normally
        ack_at = 64;
        exp_gnt(1'b1, 30'h60, 4'hF, 1'b0, 1'b0, 32'h0);
        exp_rsp(1'b1, 1'b0, rd_of(30'h60));
        set_d(30'h60, 1'b0, 4'hF, 32'h0, 1'b0);
        d_req = 1'b1;
        wait_valid(1'b1, 100, "boundary", c);
        d_req = 1'b0;
        chk("boundary_latency", 128'(c), 128'(65));
        tick();

        // Reset in the middle of a transaction
        ack_at = 0;
        exp_gnt(1'b1, 30'h70, 4'hF, 1'b0, 1'b0, 32'h0);
        set_d(30'h70, 1'b0, 4'hF, 32'h0, 1'b0);
        d_req = 1'b1;
        tick(); tick();
        chk("midreset_pre", 128'(bus_req), 128'(1));
        #2;
        async_rst_n = 1'b0;
        #1;
        chk("midreset_busreq", 128'(bus_req), 128'(0));
        d_req = 1'b0;
        @(negedge clk);
        async_rst_n = 1'b1;
        tick();
        inject_ack = 1'b1;
        tick();
        inject_ack = 1'b0;
        vcount = 0;
        for (int k = 0; k < 5; k++) begin
            if (if_valid || d_valid || bus_req) vcount++;
            tick();
        end
        chk("midreset_ack_ignored", 128'(vcount), 128'(0));

        chk("grant_queue_drained", 128'(gq.size()), 128'(0));
        chk("rsp_queue_drained", 128'(rq.size()), 128'(0));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
